// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the TRACEDATA transmitter:
//   - trace_state_e : packet type currently occupying the trace port
//   - FSYNC_BYTE0..3: TPIU full-sync packet, FF FF FF 7F
//   - HSYNC_BYTE0..1: halfword-sync idle filler, FF 7F
//   - *_LAST_IDX    : byte index of the final byte of each packet type
// -----------------------------------------------------------------------------
package trace_pkg;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FSYNC = 2'd1,
    ST_HSYNC = 2'd2,
    ST_DATA  = 2'd3
  } trace_state_e;

  localparam logic [DATA_W-1:0] FSYNC_BYTE0 = 8'hFF;
  localparam logic [DATA_W-1:0] FSYNC_BYTE1 = 8'hFF;
  localparam logic [DATA_W-1:0] FSYNC_BYTE2 = 8'hFF;
  localparam logic [DATA_W-1:0] FSYNC_BYTE3 = 8'h7F;

  localparam logic [DATA_W-1:0] HSYNC_BYTE0 = 8'hFF;
  localparam logic [DATA_W-1:0] HSYNC_BYTE1 = 8'h7F;

  localparam logic [1:0] FSYNC_LAST_IDX = 2'd3;
  localparam logic [1:0] HSYNC_LAST_IDX = 2'd1;
  localparam logic [1:0] DATA_LAST_IDX  = 2'd0;

endpackage : trace_pkg

// File: rtl/trace_port_tx.sv
// -----------------------------------------------------------------------------
// trace_port_tx
// Parallel trace-port transmitter. Serialises a byte stream onto a 4-bit
// TRACEDATA port (low nibble first, one nibble per clock), inserts full-sync
// packets at start-up and every pSYNC_PERIOD data bytes, and fills idle time
// with halfword-sync packets.
//
// Ports:
//   trace_clk     in   sole clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   1 = transmit; 0 = finish current packet, then go quiet
//   I_data[7:0]   in   byte to transmit
//   I_valid       in   I_data valid
//   O_ready       out  byte taken this cycle if I_valid=1 (never looks at I_valid)
//   O_trace_data  out  registered TRACEDATA nibble
//   O_busy        out  1 whenever a packet is on the port
//   O_sync_count  out  number of full-sync packets sent, wraps at 255
//
// The state registers (r_state, r_idx, r_phase) describe the nibble that is
// currently on O_trace_data. The next-slot values are computed combinationally
// and the matching nibble is registered on the same edge, so a byte accepted
// on a decision cycle shows its low nibble in the very next cycle.
// -----------------------------------------------------------------------------
module trace_port_tx
  import trace_pkg::*;
#(
  parameter int pSYNC_PERIOD = 256,
  parameter int pCNT_WIDTH   = 16
) (
  input  logic              trace_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] I_data,
  input  logic              I_valid,
  output logic              O_ready,
  output logic [NIB_W-1:0]  O_trace_data,
  output logic              O_busy,
  output logic [7:0]        O_sync_count
);

  localparam logic [pCNT_WIDTH-1:0] SYNC_PERIOD_C = pCNT_WIDTH'(pSYNC_PERIOD);

  trace_state_e            r_state;
  logic [1:0]              r_idx;
  logic                    r_phase;
  logic [pCNT_WIDTH-1:0]   r_byte_cnt;
  logic [DATA_W-1:0]       r_data;
  logic [NIB_W-1:0]        r_trace_data;
  logic [7:0]              r_sync_count;

  trace_state_e            w_nstate;
  logic [1:0]              w_nidx;
  logic                    w_nphase;
  logic [1:0]              w_last_idx;
  logic                    w_decide;
  logic                    w_period_hit;
  logic                    w_ready;
  logic                    w_load;
  logic                    w_cnt_clr;
  logic [DATA_W-1:0]       w_next_byte;
  logic [NIB_W-1:0]        w_next_nib;
  logic                    w_fsync_done;

  // Index of the final byte of the packet currently on the port
  always_comb begin
    w_last_idx = DATA_LAST_IDX;
    case (r_state)
      ST_FSYNC: w_last_idx = FSYNC_LAST_IDX;
      ST_HSYNC: w_last_idx = HSYNC_LAST_IDX;
      default:  w_last_idx = DATA_LAST_IDX;
    endcase
  end

  // A decision is taken while the high nibble of a packet's last byte is out
  assign w_decide     = (r_state != ST_IDLE) && r_phase && (r_idx == w_last_idx);
  assign w_period_hit = (r_byte_cnt == SYNC_PERIOD_C);
  assign w_ready      = w_decide && enable && !w_period_hit;

  // Next-slot FSM
  always_comb begin
    w_nstate  = r_state;
    w_nidx    = r_idx;
    w_nphase  = r_phase;
    w_load    = 1'b0;
    w_cnt_clr = 1'b0;

    if (r_state == ST_IDLE) begin
      if (enable) begin
        // A fresh start always opens with a full sync and a new period
        w_nstate  = ST_FSYNC;
        w_nidx    = 2'd0;
        w_nphase  = 1'b0;
        w_cnt_clr = 1'b1;
      end
    end else if (!r_phase) begin
      w_nphase = 1'b1;
    end else if (!w_decide) begin
      w_nidx   = r_idx + 2'd1;
      w_nphase = 1'b0;
    end else begin
      w_nidx   = 2'd0;
      w_nphase = 1'b0;
      if (!enable) begin
        w_nstate = ST_IDLE;
      end else if (w_period_hit) begin
        w_nstate  = ST_FSYNC;
        w_cnt_clr = 1'b1;
      end else if (I_valid) begin
        w_nstate = ST_DATA;
        w_load   = 1'b1;
      end else begin
        w_nstate = ST_HSYNC;
      end
    end
  end

  // Byte that will occupy the next slot, then pick its nibble
  always_comb begin
    w_next_byte = '0;
    case (w_nstate)
      ST_FSYNC: begin
        case (w_nidx)
          2'd0:    w_next_byte = FSYNC_BYTE0;
          2'd1:    w_next_byte = FSYNC_BYTE1;
          2'd2:    w_next_byte = FSYNC_BYTE2;
          default: w_next_byte = FSYNC_BYTE3;
        endcase
      end
      ST_HSYNC: w_next_byte = w_nidx[0] ? HSYNC_BYTE1 : HSYNC_BYTE0;
      ST_DATA:  w_next_byte = w_load ? I_data : r_data;
      default:  w_next_byte = '0;
    endcase
    w_next_nib = w_nphase ? w_next_byte[7:4] : w_next_byte[3:0];
  end

  // The 7 of a full sync is driven on the edge entering its last slot
  assign w_fsync_done = (w_nstate == ST_FSYNC) && (w_nidx == FSYNC_LAST_IDX) && w_nphase;

  // ---- control / output register stage ----
  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 2'd0;
      r_phase      <= 1'b0;
      r_byte_cnt   <= '0;
      r_trace_data <= '0;
      r_sync_count <= 8'd0;
    end else begin
      r_state      <= w_nstate;
      r_idx        <= w_nidx;
      r_phase      <= w_nphase;
      r_trace_data <= w_next_nib;
      if (w_cnt_clr) begin
        r_byte_cnt <= '0;
      end else if (w_load && !w_period_hit) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (w_fsync_done) begin
        r_sync_count <= r_sync_count + 8'd1;
      end
    end
  end

  // Held data byte; only read while in DATA, so it needs no reset
  always_ff @(posedge trace_clk) begin
    if (w_load) begin
      r_data <= I_data;
    end
  end

  assign O_ready      = w_ready;
  assign O_trace_data = r_trace_data;
  assign O_busy       = (r_state != ST_IDLE);
  assign O_sync_count = r_sync_count;

endmodule : trace_port_tx

// File: tb/tb_trace_port_tx.sv
module tb_trace_port_tx;

  localparam int P = 4;

  logic       trace_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       enable    = 1'b0;
  logic [7:0] I_data    = 8'h00;
  logic       I_valid   = 1'b0;
  logic       O_ready;
  logic [3:0] O_trace_data;
  logic       O_busy;
  logic [7:0] O_sync_count;

  trace_port_tx #(.pSYNC_PERIOD(P), .pCNT_WIDTH(16)) dut (
    .trace_clk    (trace_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .I_data       (I_data),
    .I_valid      (I_valid),
    .O_ready      (O_ready),
    .O_trace_data (O_trace_data),
    .O_busy       (O_busy),
    .O_sync_count (O_sync_count)
  );

  always #5 trace_clk = ~trace_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the nibble on the wire plus a queue of the nibbles
  // still owed by the current packet.
  bit         m_busy;
  logic [3:0] m_cur;
  logic [3:0] m_q[$];
  bit         m_fsync_pkt;
  int         m_cnt;
  logic [7:0] m_syncs;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    m_busy = 0; m_cur = 4'h0; m_q.delete(); m_fsync_pkt = 0; m_cnt = 0; m_syncs = 8'd0;
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    m_q.push_back(b[3:0]);
    m_q.push_back(b[7:4]);
  endfunction

  function automatic void start_sync(input bit full);
    if (full) begin
      add_byte(8'hFF); add_byte(8'hFF); add_byte(8'hFF); add_byte(8'h7F);
    end else begin
      add_byte(8'hFF); add_byte(8'h7F);
    end
    m_fsync_pkt = full;
    m_busy = 1;
    m_cur = m_q.pop_front();
  endfunction

  function automatic bit model_ready(input bit en);
    return m_busy && (m_q.size() == 0) && en && (m_cnt != P);
  endfunction

  function automatic bit model_step(input bit en, input bit v, input logic [7:0] d);
    bit acc = 0;
    if (!m_busy) begin
      if (en) begin m_cnt = 0; start_sync(1); end
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      if (m_q.size() == 0 && m_fsync_pkt) m_syncs = m_syncs + 8'd1;
    end else if (!en) begin
      m_busy = 0; m_cur = 4'h0;
    end else if (m_cnt == P) begin
      m_cnt = 0; start_sync(1);
    end else if (v) begin
      m_fsync_pkt = 0;
      add_byte(d);
      m_cur = m_q.pop_front();
      if (m_cnt < P) m_cnt++;
      acc = 1;
    end else begin
      start_sync(0);
    end
    return acc;
  endfunction

  // One clock: drive inputs, check O_ready, advance, check registered outputs
  task automatic cyc(input bit en, input bit v, input logic [7:0] d, output bit acc);
    enable = en; I_valid = v; I_data = d;
    #1;
    check("ready", {7'b0, O_ready}, {7'b0, model_ready(en)});
    acc = model_step(en, v, d);
    @(posedge trace_clk); #1;
    check("trace_data", {4'b0, O_trace_data}, {4'b0, m_cur});
    check("busy", {7'b0, O_busy}, {7'b0, m_busy});
    check("sync_count", O_sync_count, m_syncs);
  endtask

  task automatic idle_cycles(input bit en, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 8'h00, acc);
  endtask

  // Asynchronous reset pulse in the middle of a cycle
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_trace_data", {4'b0, O_trace_data}, 8'h00);
    check("rst_busy", {7'b0, O_busy}, 8'h00);
    check("rst_ready", {7'b0, O_ready}, 8'h00);
    check("rst_sync_count", O_sync_count, 8'h00);
    model_reset();
    @(posedge trace_clk); #1;
    reset_n = 1'b1;
  endtask

  // Offer bytes back-to-back until all are taken or the budget runs out
  task automatic send(input logic [7:0] b0, input int n, input bit incr, input bit hold_valid);
    int idx = 0;
    int budget = 200;
    bit acc;
    logic [7:0] b;
    b = b0;
    while (idx < n && budget > 0) begin
      cyc(1'b1, 1'b1, b, acc);
      if (acc) begin
        idx++;
        b = incr ? b + 8'd1 : b;
      end
      budget--;
    end
    check("send_all_taken", 8'(idx), 8'(n));
    if (!hold_valid) I_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [7:0] pat [3];
    model_reset();
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h00;

    // Reset state
    @(posedge trace_clk); #1;
    check("init_trace_data", {4'b0, O_trace_data}, 8'h00);
    check("init_busy", {7'b0, O_busy}, 8'h00);
    check("init_ready", {7'b0, O_ready}, 8'h00);
    check("init_sync_count", O_sync_count, 8'h00);
    reset_n = 1'b1;
    idle_cycles(1'b0, 2);

    // 1: FSYNC then HSYNC filler
    idle_cycles(1'b1, 21);
    check("t1_syncs", O_sync_count, 8'd1);

    // 2: back-to-back data bytes
    for (int i = 0; i < 3; i++) begin
      int budget = 8;
      acc = 0;
      while (!acc && budget > 0) begin cyc(1'b1, 1'b1, pat[i], acc); budget--; end
      check("t2_taken", {7'b0, acc}, 8'h01);
    end
    idle_cycles(1'b1, 6);

    // 3: period expiry inserts a full sync between data bytes
    do_reset();
    idle_cycles(1'b1, 7);
    send(8'h01, 6, 1'b1, 1'b0);
    idle_cycles(1'b1, 6);
    check("t3_syncs", O_sync_count, 8'd2);

    // 4: enable dropped early in an FSYNC
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, acc);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h55, acc);
    check("t4_quiet_busy", {7'b0, O_busy}, 8'h00);
    check("t4_quiet_data", {4'b0, O_trace_data}, 8'h00);
    idle_cycles(1'b1, 12);

    // 5: I_valid rises mid-HSYNC with 7F
    idle_cycles(1'b1, 1);
    send(8'h7F, 1, 1'b0, 1'b0);
    idle_cycles(1'b1, 8);

    // 6: reset mid-DATA, then clean restart
    send(8'h96, 1, 1'b0, 1'b1);
    do_reset();
    idle_cycles(1'b1, 12);
    check("t6_syncs", O_sync_count, 8'd1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1, 8'($urandom), acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_trace_port_tx

// File: doc/trace_port_tx.md
Name: trace_port_tx

Overview:
Parallel trace-port transmitter. It is the transmit end of the 4-bit TRACEDATA interface that the trace capture path receives.
- Accepts a byte stream through a valid/ready handshake.
- Serialises each byte as two nibbles on a 4-bit port, low nibble first, one nibble per trace_clk.
- Inserts TPIU full-sync packets at start-up and periodically.
- Fills idle time with halfword-sync packets.

It drives target-emulation and loopback test setups for the trace capture path.

Parameters:
pSYNC_PERIOD, 256, number of data bytes between forced full-sync packets; legal range 2..65535.
pCNT_WIDTH, 16, width of the data-byte counter; must hold pSYNC_PERIOD.

Ports:
trace_clk  input  1  sole clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  level; 1 = transmit, 0 = finish current packet then go quiet
I_data  input  8  byte to transmit
I_valid  input  1  I_data valid
O_ready  output  1  byte accepted on this cycle if I_valid=1
O_trace_data  output  4  TRACEDATA nibble, registered
O_busy  output  1  1 whenever the state is not IDLE
O_sync_count  output  8  full-sync packets sent; wraps 255->0

Behaviour:
- Reset (async, reset_n=0) values: O_trace_data=0, O_ready=0, O_busy=0, O_sync_count=0, state IDLE, phase=0, byte counter=0.
- Slots:
  - Each byte occupies a 2-cycle slot: phase 0 drives low nibble, phase 1 drives high nibble.
  - O_trace_data is registered; the nibble for byte B appears one cycle after B is loaded.
- States:
  - IDLE: O_trace_data=0.
  - FSYNC: bytes FF FF FF 7F.
  - HSYNC: bytes FF 7F.
  - DATA: one accepted byte.
- IDLE -> FSYNC on the cycle enable is sampled 1. First nibble appears the following cycle. Full nibble sequence is F,F,F,F,F,F,F,7.
- Next-byte decision at the end of every packet, on the phase-1 cycle of its last byte, in priority order:
  1. enable=0 -> IDLE.
  2. Byte counter = pSYNC_PERIOD -> FSYNC; counter cleared.
  3. Else DATA if I_valid=1.
  4. Else HSYNC (nibbles F,F,F,7).
- O_ready:
  - Asserted only on decision cycles where rules 1 and 2 do not apply.
  - It is a function of state, phase, enable and counter only; it never depends on I_valid.
  - Transfer occurs when O_ready & I_valid.
  - Accepted byte's low nibble appears next cycle; high nibble the cycle after.
  - Max throughput is 1 byte per 2 cycles.
- Byte counter: increments once per accepted DATA byte, saturating at pSYNC_PERIOD. It does not count sync bytes.
- O_sync_count increments when an FSYNC packet's final nibble (7) is driven.
- Packets are atomic:
  - A full or halfword sync is never interrupted by data, enable=0, or a sync-period expiry.
  - enable falling mid-packet completes the packet, then goes to IDLE. O_trace_data returns to 0 on the cycle after the last nibble.
- enable re-asserted while still finishing a packet after a fall: it is seen at the decision cycle, and the transmitter continues with rules 2-4. No extra FSYNC is inserted.
- A data byte equal to FF or 7F is sent verbatim; no escaping is applied.
- reset_n asserted mid-packet aborts immediately to reset values. The packet is truncated.

Decomposition:
- Shared package (trace_pkg) holds:
  - state encoding IDLE/FSYNC/HSYNC/DATA;
  - constants FSYNC_BYTE0..3 = FF,FF,FF,7F;
  - constants HSYNC_BYTE0..1 = FF,7F.
- No sub-module.
- Single FSM with a 2-bit byte index within the packet and a phase bit. Packet byte lookup and nibble select are inline.

Test Plan:
1. Reset, then enable=1, I_valid=0 -> O_trace_data = F,F,F,F,F,F,F,7, then repeating F,F,F,7. O_sync_count=1; O_ready pulses once every 4 cycles.
2. Continuous I_valid=1 with bytes A5, 3C, 00 after the first FSYNC -> nibbles 5,A,C,3,0,0 back-to-back. O_ready is high every second cycle.
3. pSYNC_PERIOD=4, continuous data 01..06 -> nibbles for 01..04, then F,F,F,F,F,F,F,7, then 05, 06. O_sync_count=2.
4. enable dropped on the 2nd nibble of an FSYNC -> remaining 6 nibbles complete, then O_trace_data=0 and O_busy=0 with no data accepted. Re-enable -> fresh FSYNC.
5. I_valid rises mid-HSYNC with data 7F -> HSYNC completes (F,F,F,7), then F,7 for the data byte. The byte is accepted exactly once.
6. reset_n pulsed low mid-DATA slot -> outputs are 0 asynchronously. After release with enable=1, the sequence restarts with FSYNC and O_sync_count=1.
